// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer arbiter. Display reads always win; queued capture writes
// fill the cycles where the display address did not change.
`timescale 1ns/1ps
module fb_port_arbiter #(
  parameter int ADDRW     = 14,
  parameter int DATAW     = 36,
  parameter int WQ_DEPTH  = 4,
  parameter int STALL_LIM = 64
) (
  input  logic                       pxlClk,
  input  logic                       rstN,
  input  logic [ADDRW-1:0]           rdAddr,
  input  logic                       rdFlush,
  output logic [DATAW-1:0]           rdData,
  input  logic                       wrValid,
  output logic                       wrReady,
  input  logic [ADDRW-1:0]           wrAddr,
  input  logic [DATAW-1:0]           wrData,
  output logic [ADDRW-1:0]           ramAddr,
  output logic                       ramWe,
  output logic [DATAW-1:0]           ramWdata,
  input  logic [DATAW-1:0]           ramRdata,
  output logic [$clog2(WQ_DEPTH):0]  wqLevel,
  output logic                       stallFlag,
  input  logic                       clrStall
);

  localparam int PW = $clog2(WQ_DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(STALL_LIM + 1);

  logic [ADDRW-1:0] last_addr_reg;
  logic             last_valid_reg;
  logic             rd_pend_reg;
  logic [DATAW-1:0] rd_data_reg;
  logic [ADDRW-1:0] wq_addr_mem [WQ_DEPTH];
  logic [DATAW-1:0] wq_data_mem [WQ_DEPTH];
  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]    count_reg;
  logic [CW-1:0]    stall_cnt_reg;
  logic             stall_flag_reg;

  logic             rd_need, wq_full, wq_empty, do_push, do_pop, fwd, stall_hit;
  logic [ADDRW-1:0] head_addr;
  logic [DATAW-1:0] head_data;

  always_comb begin
    rd_need   = !last_valid_reg || rdFlush || (rdAddr != last_addr_reg);
    wq_full   = (count_reg == LW'(WQ_DEPTH));
    wq_empty  = (count_reg == '0);
    head_addr = wq_addr_mem[rd_ptr_reg];
    head_data = wq_data_mem[rd_ptr_reg];
    do_pop    = !rd_need && !wq_empty;
    do_push   = wrValid && !wq_full;
    // A write to the line currently on display must also refresh the holding register.
    fwd       = do_pop && last_valid_reg && (head_addr == last_addr_reg);
    stall_hit = wq_full && (stall_cnt_reg >= CW'(STALL_LIM - 1));
  end

  assign ramAddr   = rd_need ? rdAddr : (do_pop ? head_addr : last_addr_reg);
  assign ramWe     = do_pop;
  assign ramWdata  = head_data;
  assign rdData    = rd_data_reg;
  assign wrReady   = !wq_full;
  assign wqLevel   = count_reg;
  assign stallFlag = stall_flag_reg;

  // Queue storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge pxlClk) begin
    if (do_push) begin
      wq_addr_mem[wr_ptr_reg] <= wrAddr;
      wq_data_mem[wr_ptr_reg] <= wrData;
    end
  end

  always_ff @(posedge pxlClk or negedge rstN) begin
    if (!rstN) begin
      last_addr_reg  <= '0;
      last_valid_reg <= 1'b0;
      rd_pend_reg    <= 1'b0;
      rd_data_reg    <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      stall_cnt_reg  <= '0;
      stall_flag_reg <= 1'b0;
    end else begin
      rd_pend_reg <= rd_need;
      if (rd_need) begin
        last_addr_reg  <= rdAddr;
        last_valid_reg <= 1'b1;
      end

      if (fwd)
        rd_data_reg <= head_data;
      else if (rd_pend_reg)
        rd_data_reg <= ramRdata;

      if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + LW'(1);
        2'b01:   count_reg <= count_reg - LW'(1);
        default: count_reg <= count_reg;
      endcase

      if (clrStall) begin
        stall_cnt_reg  <= '0;
        stall_flag_reg <= 1'b0;
      end else begin
        if (!wq_full)
          stall_cnt_reg <= '0;
        else if (stall_cnt_reg < CW'(STALL_LIM))
          stall_cnt_reg <= stall_cnt_reg + CW'(1);
        if (stall_hit)
          stall_flag_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: behavioural RAM, write scoreboard checked at the RAM port,
// directed read/forwarding/stall/reset scenarios.
`timescale 1ns/1ps
module tb_fb_port_arbiter;
  localparam int ADDRW = 14;
  localparam int DATAW = 36;

  logic             pxlClk = 1'b0;
  logic             rstN;
  logic [ADDRW-1:0] rdAddr;
  logic             rdFlush;
  logic [DATAW-1:0] rdData;
  logic             wrValid;
  logic             wrReady;
  logic [ADDRW-1:0] wrAddr;
  logic [DATAW-1:0] wrData;
  logic [ADDRW-1:0] ramAddr;
  logic             ramWe;
  logic [DATAW-1:0] ramWdata;
  logic [DATAW-1:0] ramRdata;
  logic [2:0]       wqLevel;
  logic             stallFlag;
  logic             clrStall;

  int n_checks = 0;
  int n_fails  = 0;

  fb_port_arbiter #(.ADDRW(ADDRW), .DATAW(DATAW), .WQ_DEPTH(4), .STALL_LIM(64)) dut (
    .pxlClk(pxlClk), .rstN(rstN), .rdAddr(rdAddr), .rdFlush(rdFlush), .rdData(rdData),
    .wrValid(wrValid), .wrReady(wrReady), .wrAddr(wrAddr), .wrData(wrData),
    .ramAddr(ramAddr), .ramWe(ramWe), .ramWdata(ramWdata), .ramRdata(ramRdata),
    .wqLevel(wqLevel), .stallFlag(stallFlag), .clrStall(clrStall)
  );

  always #5 pxlClk = ~pxlClk;

  function automatic logic [DATAW-1:0] init_val(input logic [ADDRW-1:0] a);
    return (a == 14'h0010) ? 36'hABC : {8'hC3, a, a};
  endfunction

  // Behavioural RAM with one-cycle registered read.
  logic [DATAW-1:0] ram_mem [1 << ADDRW];
  logic             ram_written [1 << ADDRW];
  always @(posedge pxlClk) begin
    ramRdata <= ram_written[ramAddr] ? ram_mem[ramAddr] : init_val(ramAddr);
    if (ramWe) begin
      ram_mem[ramAddr]     <= ramWdata;
      ram_written[ramAddr] <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge pxlClk);
    #1;
  endtask

  // Scoreboard: accepted writes go in, RAM-port writes come out in order.
  logic [ADDRW+DATAW-1:0] exp_wq [$];
  logic [ADDRW-1:0]       tb_last;
  logic                   tb_valid = 1'b0;

  always @(negedge pxlClk) begin
    if (!rstN) begin
      exp_wq.delete();
      tb_valid = 1'b0;
    end else begin
      logic need;
      need = !tb_valid || rdFlush || (rdAddr != tb_last);
      if (ramWe) begin
        check("wr_in_read_slot", 64'(need), 64'd0);
        if (exp_wq.size() == 0) begin
          check("wr_unexpected", 64'(ramWe), 64'd0);
        end else begin
          logic [ADDRW+DATAW-1:0] e;
          e = exp_wq.pop_front();
          $display("ram write addr=%h data=%h", ramAddr, ramWdata);
          check("wr_addr", 64'(ramAddr), 64'(e[ADDRW+DATAW-1:DATAW]));
          check("wr_data", 64'(ramWdata), 64'(e[DATAW-1:0]));
        end
      end
      if (wrValid && wrReady) begin
        $display("push addr=%h data=%h", wrAddr, wrData);
        exp_wq.push_back({wrAddr, wrData});
      end
      if (need) begin
        tb_last  = rdAddr;
        tb_valid = 1'b1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstN = 1'b0; rdAddr = 14'h0010; rdFlush = 1'b0; wrValid = 1'b0;
    wrAddr = '0; wrData = '0; clrStall = 1'b0;
    repeat (3) @(posedge pxlClk);
    #1;
    check("rst_rdData", 64'(rdData), 64'd0);
    check("rst_level", 64'(wqLevel), 64'd0);
    check("rst_ready", 64'(wrReady), 64'd1);
    check("rst_we", 64'(ramWe), 64'd0);
    check("rst_stall", 64'(stallFlag), 64'd0);

    // Static address after reset: one read, data from cycle 2.
    rstN = 1'b1;
    @(negedge pxlClk);
    check("c0_ramAddr", 64'(ramAddr), 64'h10);
    check("c0_we", 64'(ramWe), 64'd0);
    @(negedge pxlClk);
    check("c1_rdData", 64'(rdData), 64'd0);
    @(negedge pxlClk);
    check("c2_rdData", 64'(rdData), 64'hABC);
    repeat (3) @(negedge pxlClk);
    check("hold_rdData", 64'(rdData), 64'hABC);

    // Address changes every 2 cycles, 3 back-to-back writes.
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 2; j++) begin
        next_cycle();
        rdAddr  = ADDRW'(k);
        wrValid = (2 * k + j) < 3;
        wrAddr  = ADDRW'(14'h2000 + 2 * k + j);
        wrData  = DATAW'({$urandom(), $urandom()});
        @(negedge pxlClk);
        if (j == 1 && k >= 1)
          check("alt_rdData", 64'(rdData), 64'(init_val(ADDRW'(k - 1))));
      end
    end
    next_cycle();
    wrValid = 1'b0;
    for (int i = 0; i < 20 && wqLevel != 0; i++) next_cycle();
    check("alt_drained", 64'(wqLevel), 64'd0);
    check("alt_sb_empty", 64'(exp_wq.size()), 64'd0);

    // Continuous address change: queue fills, stall flag, clear, then drain.
    for (int n = 0; n < 82; n++) begin
      next_cycle();
      if (n < 77) rdAddr = ADDRW'(14'h0100 + n);
      wrValid  = (n < 5);
      wrAddr   = ADDRW'(14'h2100 + n);
      wrData   = DATAW'({$urandom(), $urandom()});
      clrStall = (n == 75);
      @(negedge pxlClk);
      if (n == 4) begin
        check("full_level", 64'(wqLevel), 64'd4);
        check("full_ready", 64'(wrReady), 64'd0);
      end
      if (n == 14) check("stall_early", 64'(stallFlag), 64'd0);
      if (n == 74) check("stall_set", 64'(stallFlag), 64'd1);
      if (n == 76) check("stall_clr", 64'(stallFlag), 64'd0);
      if (n >= 77) check("drain_level", 64'(wqLevel), 64'(4 - (n - 77)));
    end
    clrStall = 1'b0;

    // Forwarding of a write to the displayed address.
    next_cycle();
    rdAddr = 14'h0100; wrValid = 1'b0;
    repeat (3) @(negedge pxlClk);
    check("fwd_before", 64'(rdData), 64'(init_val(14'h0100)));
    next_cycle();
    wrValid = 1'b1; wrAddr = 14'h0100; wrData = 36'h123;
    @(negedge pxlClk);
    next_cycle();
    wrValid = 1'b0;
    @(negedge pxlClk);
    check("fwd_we", 64'(ramWe), 64'd1);
    check("fwd_old", 64'(rdData), 64'(init_val(14'h0100)));
    next_cycle();
    @(negedge pxlClk);
    check("fwd_new", 64'(rdData), 64'h123);

    // Full queue: refused push during pop, then flush steals the write slot.
    for (int n = 0; n < 5; n++) begin
      next_cycle();
      rdAddr  = ADDRW'(14'h0200 + n);
      wrValid = (n < 4);
      wrAddr  = ADDRW'(14'h2200 + n);
      wrData  = DATAW'({$urandom(), $urandom()});
    end
    @(negedge pxlClk);
    check("t5_full", 64'(wqLevel), 64'd4);
    next_cycle();
    wrValid = 1'b1; wrAddr = 14'h2FFF; wrData = 36'hFFF;
    @(negedge pxlClk);
    check("t5_refused", 64'(wrReady), 64'd0);
    check("t5_pop_we", 64'(ramWe), 64'd1);
    next_cycle();
    wrValid = 1'b0; rdFlush = 1'b1;
    @(negedge pxlClk);
    check("t5_level3", 64'(wqLevel), 64'd3);
    check("flush_we", 64'(ramWe), 64'd0);
    check("flush_addr", 64'(ramAddr), 64'h204);
    next_cycle();
    rdFlush = 1'b0;
    @(negedge pxlClk);
    check("flush_slot_lost", 64'(wqLevel), 64'd3);
    next_cycle();
    @(negedge pxlClk);
    check("flush_rdData", 64'(rdData), 64'(init_val(14'h0204)));
    for (int i = 0; i < 10 && wqLevel != 0; i++) next_cycle();
    check("t5_drained", 64'(wqLevel), 64'd0);

    // Reset with queued writes.
    for (int n = 0; n < 4; n++) begin
      next_cycle();
      rdAddr  = ADDRW'(14'h0300 + n);
      wrValid = (n < 3);
      wrAddr  = ADDRW'(14'h2300 + n);
      wrData  = DATAW'({$urandom(), $urandom()});
    end
    @(negedge pxlClk);
    check("t6_level3", 64'(wqLevel), 64'd3);
    next_cycle();
    rstN = 1'b0; rdAddr = 14'h0155;
    #1;
    check("t6_rst_we", 64'(ramWe), 64'd0);
    check("t6_rst_level", 64'(wqLevel), 64'd0);
    check("t6_rst_rdData", 64'(rdData), 64'd0);
    check("t6_rst_ready", 64'(wrReady), 64'd1);
    next_cycle();
    next_cycle();
    rstN = 1'b1;
    @(negedge pxlClk);
    check("t6_c0_addr", 64'(ramAddr), 64'h155);
    check("t6_c0_we", 64'(ramWe), 64'd0);
    repeat (2) @(negedge pxlClk);
    check("t6_rdData", 64'(rdData), 64'(init_val(14'h0155)));
    repeat (5) @(negedge pxlClk);
    check("final_sb_empty", 64'(exp_wq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
